bus_split_arbiter: RTL and testbench
====================================

Name: bus_split_arbiter

Overview:
- Two-master system-bus arbiter with fixed master-1 priority, hold-until-release ownership, slave-initiated split transactions and an anti-starvation hold timeout.
- Drives the master grant lines and the M_select code that steers the bus address/data multiplexers.
- Sits between the master request ports and the bus mux/slave decoder.

Parameters:
- TIMEOUT_CYCLES, 64, maximum consecutive cycles an owner keeps the bus while the other master is eligible and requesting; range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  bus clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- m1_req  input  1  master 1 bus request; held high for the whole transaction.
- m2_req  input  1  master 2 bus request.
- split  input  1  current slave splits the current owner's transaction; single-cycle pulse.
- split_release  input  2  bit0 resumes master 1, bit1 resumes master 2; single-cycle pulses.
- m1_grant  output  1  master 1 owns the bus.
- m2_grant  output  1  master 2 owns the bus.
- M_select  output  2  2'b00 = none, 2'b01 = M1, 2'b10 = M2; 2'b11 is never driven.
- split_status  output  2  bit0 = master 1 parked by split, bit1 = master 2 parked by split.

Behaviour:
- All outputs are registered.
- Reset value of every output and flag is 0. FSM resets to IDLE and the hold counter to 0. Reset asserted mid-transaction drops the grant on that edge and clears the split flags.
- Eligible master: req=1 and its split flag is 0.
- FSM states: IDLE, OWN_M1, OWN_M2. m1_grant=1 only in OWN_M1 and m2_grant=1 only in OWN_M2. M_select={m2_grant,m1_grant}. At most one grant is high in any cycle.
- IDLE:
  - M1 eligible -> OWN_M1.
  - Otherwise M2 eligible -> OWN_M2.
  - Otherwise stay.
  - Latency is 1 cycle: a request sampled at edge N gives the grant high after edge N.
- OWN_Mx, owner req drops: move to the other master's state if it is eligible, otherwise IDLE. There is no idle bubble on handover.
- OWN_Mx, split=1: set the owner's split flag. Move to the other master's state if it is eligible, otherwise IDLE. split has priority over req-drop and timeout in the same cycle.
- split in IDLE is ignored.
- Timeout:
  - The hold counter clears on every entry to OWN_Mx.
  - It increments each cycle in OWN_Mx while the other master is eligible, and holds otherwise.
  - When the counter equals TIMEOUT_CYCLES-1 and the other master is still eligible, ownership is forced to the other master on the next edge.
  - The preempted master keeps its req and is re-arbitrated normally.
- Priority: master 1 wins only on arbitration from IDLE. An owner is never preempted except by timeout or split.
- split_release bit k clears split flag k. If split sets and split_release clears the same flag in one cycle, the set wins.
- Both flags may be set at once. In that case the FSM stays IDLE until a release arrives.
- A release for a master that is not parked has no effect.
- A parked master whose req is high becomes eligible the cycle after its release, then follows the normal IDLE/handover rules.

Test Plan:
- Reset and single request: rst high 2 cycles -> all outputs 0. m1_req=1 at cycle 3 -> m1_grant=1, M_select=01 from cycle 4. m1_req=0 at cycle 8 -> m1_grant=0, M_select=00 from cycle 9.
- Simultaneous request: m1_req=m2_req=1 from IDLE -> M_select=01. Drop m1_req -> next cycle M_select=10, with no 00 cycle in between.
- Hold, no preemption: M2 owns, then m1_req rises -> M2 keeps the grant until m2_req drops (provided fewer than TIMEOUT_CYCLES cycles elapse), then M_select=01 the following cycle.
- Timeout with TIMEOUT_CYCLES=4: M1 owns and m2_req is held high -> M_select=10 exactly 4 cycles after m2_req was first sampled. M1 regains the bus after a further 4 cycles if both requests stay high.
- Split and release: M1 owns, split pulse with m2_req=1 -> next cycle M_select=10, split_status=01. m1_req held high is ignored. split_release=01 -> split_status=00. When m2_req drops, M_select=01.
- Corner cases:
  - split in IDLE -> split_status stays 00.
  - split and split_release[0] on the same edge while M1 owns -> split_status=01.
  - rst asserted asynchronously mid-grant -> grants, M_select and split_status go to 0 before the next clock edge.

Source files
------------

// File: rtl/bus_split_arbiter_if.sv
// Bus-arbiter signal bundle.
// Groups the master request/split lines and the arbiter grant/select
// outputs so they can be passed as one port.
//   m1_req, m2_req   : master bus requests
//   split            : slave splits the current owner's transaction (pulse)
//   split_release    : bit k resumes parked master k+1 (pulse)
//   m1_grant, m2_grant : ownership indications
//   M_select         : 00 none, 01 M1, 10 M2 (bus mux steering)
//   split_status     : bit k = master k+1 parked by split
// Modports: slave = arbiter side, master = requester/bus side.
interface bus_split_arbiter_if;
    logic       m1_req;
    logic       m2_req;
    logic       split;
    logic [1:0] split_release;
    logic       m1_grant;
    logic       m2_grant;
    logic [1:0] M_select;
    logic [1:0] split_status;

    modport slave (
        input  m1_req, m2_req, split, split_release,
        output m1_grant, m2_grant, M_select, split_status
    );

    modport master (
        output m1_req, m2_req, split, split_release,
        input  m1_grant, m2_grant, M_select, split_status
    );
endinterface

// File: rtl/bus_split_arbiter.sv
// Two-master bus arbiter with fixed M1 priority from IDLE, hold-until-release
// ownership, slave split parking and an anti-starvation hold timeout.
// Ports:
//   clk  : bus clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bus_split_arbiter_if.slave (requests, split controls, grants,
//          M_select, split_status); all outputs are registered state.
//
//   state  | meaning
//   IDLE   | nobody owns the bus
//   OWN_M1 | master 1 owns the bus
//   OWN_M2 | master 2 owns the bus
module bus_split_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_split_arbiter_if.slave   bus
);

    // Encoding doubles as the M_select code, so the outputs come straight
    // from the state register; 2'b11 is unreachable.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] OWN_M1 = 2'b01;
    localparam logic [1:0] OWN_M2 = 2'b10;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_split;
    logic [1:0]       w_split_nxt;
    logic [1:0]       w_split_set;
    logic             w_elig1;
    logic             w_elig2;

    assign w_elig1 = bus.m1_req & ~r_split[0];
    assign w_elig2 = bus.m2_req & ~r_split[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_split_set = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_elig1)
                    w_state_nxt = OWN_M1;
                else if (w_elig2)
                    w_state_nxt = OWN_M2;
            end
            OWN_M1: begin
                // split outranks req-drop and timeout
                if (bus.split) begin
                    w_split_set[0] = 1'b1;
                    w_state_nxt    = w_elig2 ? OWN_M2 : IDLE;
                end else if (!bus.m1_req || (w_elig2 && r_cnt == TMO_LAST)) begin
                    w_state_nxt = w_elig2 ? OWN_M2 : IDLE;
                end else if (w_elig2) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            OWN_M2: begin
                if (bus.split) begin
                    w_split_set[1] = 1'b1;
                    w_state_nxt    = w_elig1 ? OWN_M1 : IDLE;
                end else if (!bus.m2_req || (w_elig1 && r_cnt == TMO_LAST)) begin
                    w_state_nxt = w_elig1 ? OWN_M1 : IDLE;
                end else if (w_elig1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // every change of owner starts a fresh hold window
        if (w_state_nxt != r_state)
            w_cnt_nxt = '0;

        // a set on the same edge as a release wins
        w_split_nxt = w_split_set | (r_split & ~bus.split_release);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_split <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_split <= w_split_nxt;
        end
    end

    assign bus.m1_grant     = (r_state == OWN_M1);
    assign bus.m2_grant     = (r_state == OWN_M2);
    assign bus.M_select     = r_state;
    assign bus.split_status = r_split;

endmodule

// File: tb/tb_bus_split_arbiter.sv
module tb_bus_split_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bus_split_arbiter_if bif ();

    bus_split_arbiter #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed vector: {m1_grant, m2_grant, M_select, split_status}
    function automatic logic [5:0] obs();
        return {bif.m1_grant, bif.m2_grant, bif.M_select, bif.split_status};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", obs(), 6'b00_00_00);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bif.m1_req = 1'b1;
        tick();
        checks++;
        if (obs() !== 6'b10_01_00) begin
            failures++;
            $display("FAIL single_grant got=%b exp=%b", obs(), 6'b10_01_00);
        end
        repeat (4) tick();
        checks++;
        if (obs() !== 6'b10_01_00) begin
            failures++;
            $display("FAIL single_hold got=%b exp=%b", obs(), 6'b10_01_00);
        end
        bif.m1_req = 1'b0;
        tick();
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL single_release got=%b exp=%b", obs(), 6'b00_00_00);
        end
    endtask

    task automatic test_simultaneous();
        bif.m1_req = 1'b1;
        bif.m2_req = 1'b1;
        tick();
        checks++;
        if (obs() !== 6'b10_01_00) begin
            failures++;
            $display("FAIL simul_m1_wins got=%b exp=%b", obs(), 6'b10_01_00);
        end
        bif.m1_req = 1'b0;
        tick();
        checks++;
        if (obs() !== 6'b01_10_00) begin
            failures++;
            $display("FAIL simul_handover got=%b exp=%b", obs(), 6'b01_10_00);
        end
        bif.m2_req = 1'b0;
        tick();
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL simul_idle got=%b exp=%b", obs(), 6'b00_00_00);
        end
    endtask

    task automatic test_hold();
        bif.m2_req = 1'b1;
        tick();
        checks++;
        if (obs() !== 6'b01_10_00) begin
            failures++;
            $display("FAIL hold_m2_grant got=%b exp=%b", obs(), 6'b01_10_00);
        end
        bif.m1_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs() !== 6'b01_10_00) begin
                failures++;
                $display("FAIL hold_no_preempt[%0d] got=%b exp=%b", i, obs(), 6'b01_10_00);
            end
        end
        bif.m2_req = 1'b0;
        tick();
        checks++;
        if (obs() !== 6'b10_01_00) begin
            failures++;
            $display("FAIL hold_handover got=%b exp=%b", obs(), 6'b10_01_00);
        end
        bif.m1_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bif.m1_req = 1'b1;
        tick();
        bif.m2_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 6'b10_01_00) begin
                failures++;
                $display("FAIL timeout_m1_holds[%0d] got=%b exp=%b", i, obs(), 6'b10_01_00);
            end
        end
        tick();
        checks++;
        if (obs() !== 6'b01_10_00) begin
            failures++;
            $display("FAIL timeout_to_m2 got=%b exp=%b", obs(), 6'b01_10_00);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 6'b01_10_00) begin
                failures++;
                $display("FAIL timeout_m2_holds[%0d] got=%b exp=%b", i, obs(), 6'b01_10_00);
            end
        end
        tick();
        checks++;
        if (obs() !== 6'b10_01_00) begin
            failures++;
            $display("FAIL timeout_back_to_m1 got=%b exp=%b", obs(), 6'b10_01_00);
        end
        bif.m1_req = 1'b0;
        bif.m2_req = 1'b0;
        tick();
        tick();
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL timeout_idle got=%b exp=%b", obs(), 6'b00_00_00);
        end
    endtask

    task automatic test_split();
        bif.m1_req = 1'b1;
        tick();
        bif.m2_req = 1'b1;
        bif.split  = 1'b1;
        tick();
        bif.split = 1'b0;
        checks++;
        if (obs() !== 6'b01_10_01) begin
            failures++;
            $display("FAIL split_park got=%b exp=%b", obs(), 6'b01_10_01);
        end
        tick();
        checks++;
        if (obs() !== 6'b01_10_01) begin
            failures++;
            $display("FAIL split_m1_ignored got=%b exp=%b", obs(), 6'b01_10_01);
        end
        bif.split_release = 2'b01;
        tick();
        bif.split_release = 2'b00;
        checks++;
        if (obs() !== 6'b01_10_00) begin
            failures++;
            $display("FAIL split_release got=%b exp=%b", obs(), 6'b01_10_00);
        end
        bif.m2_req = 1'b0;
        tick();
        checks++;
        if (obs() !== 6'b10_01_00) begin
            failures++;
            $display("FAIL split_m1_resumes got=%b exp=%b", obs(), 6'b10_01_00);
        end
        bif.m1_req = 1'b0;
        tick();
    endtask

    task automatic test_corners();
        // split while idle does nothing
        bif.split = 1'b1;
        tick();
        bif.split = 1'b0;
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL idle_split got=%b exp=%b", obs(), 6'b00_00_00);
        end
        // set and release of the same flag on one edge: set wins
        bif.m1_req = 1'b1;
        tick();
        bif.split         = 1'b1;
        bif.split_release = 2'b01;
        tick();
        bif.split = 1'b0;
        checks++;
        if (obs() !== 6'b00_00_01) begin
            failures++;
            $display("FAIL set_beats_release got=%b exp=%b", obs(), 6'b00_00_01);
        end
        tick();
        bif.split_release = 2'b00;
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL late_release got=%b exp=%b", obs(), 6'b00_00_00);
        end
        tick();
        checks++;
        if (obs() !== 6'b10_01_00) begin
            failures++;
            $display("FAIL eligible_after_release got=%b exp=%b", obs(), 6'b10_01_00);
        end
        // park both masters
        bif.m2_req = 1'b1;
        bif.split  = 1'b1;
        tick();
        checks++;
        if (obs() !== 6'b01_10_01) begin
            failures++;
            $display("FAIL park_m1 got=%b exp=%b", obs(), 6'b01_10_01);
        end
        tick();
        bif.split = 1'b0;
        checks++;
        if (obs() !== 6'b00_00_11) begin
            failures++;
            $display("FAIL park_both got=%b exp=%b", obs(), 6'b00_00_11);
        end
        tick();
        checks++;
        if (obs() !== 6'b00_00_11) begin
            failures++;
            $display("FAIL both_parked_idle got=%b exp=%b", obs(), 6'b00_00_11);
        end
        bif.split_release = 2'b10;
        tick();
        bif.split_release = 2'b00;
        checks++;
        if (obs() !== 6'b00_00_01) begin
            failures++;
            $display("FAIL release_m2 got=%b exp=%b", obs(), 6'b00_00_01);
        end
        tick();
        checks++;
        if (obs() !== 6'b01_10_01) begin
            failures++;
            $display("FAIL m2_regrant got=%b exp=%b", obs(), 6'b01_10_01);
        end
        // asynchronous reset mid-grant
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", obs(), 6'b00_00_00);
        end
        bif.m1_req = 1'b0;
        bif.m2_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== 6'b00_00_00) begin
            failures++;
            $display("FAIL after_reset got=%b exp=%b", obs(), 6'b00_00_00);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        bif.m1_req        = 1'b0;
        bif.m2_req        = 1'b0;
        bif.split         = 1'b0;
        bif.split_release = 2'b00;
        test_reset();
        test_single();
        test_simultaneous();
        test_hold();
        test_timeout();
        test_split();
        test_corners();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
